// File: rtl/flit_vc_arbiter.sv
// flit_vc_arbiter: round-robin VC selection with per-VC credit tracking and a
// one-entry registered output stage tagged with the granted VC.
module flit_vc_arbiter #(
  parameter int unsigned LOG_NVCS    = 1,
  parameter int unsigned FLIT_WIDTH  = 36,
  parameter int unsigned MAX_CREDITS = 8,
  parameter int unsigned CW          = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                enable,
  input  logic [(FLIT_WIDTH<<LOG_NVCS)-1:0]   flit_in,
  input  logic [(1<<LOG_NVCS)-1:0]            flit_in_valid,
  output logic [(1<<LOG_NVCS)-1:0]            dequeue,
  output logic [FLIT_WIDTH-1:0]               flit_out,
  output logic [LOG_NVCS-1:0]                 flit_out_vc,
  output logic                                flit_out_valid,
  input  logic                                flit_out_ready,
  input  logic                                credit_in_valid,
  input  logic [LOG_NVCS-1:0]                 credit_in_vc,
  output logic [(CW<<LOG_NVCS)-1:0]           credit_count,
  output logic                                error
);

  localparam int unsigned NVCS = 1 << LOG_NVCS;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_CREDITS);

  logic                            flit_out_valid_q, flit_out_valid_d;
  logic [FLIT_WIDTH-1:0]           flit_out_q, flit_out_d;
  logic [LOG_NVCS-1:0]             flit_out_vc_q, flit_out_vc_d;
  logic [LOG_NVCS-1:0]             ptr_q, ptr_d;
  logic [NVCS-1:0][CW-1:0]         credit_q, credit_d;
  logic                            error_q, error_d;

  logic [NVCS-1:0]                 elig;
  logic                            free;
  logic                            grant;
  logic                            found;
  logic [LOG_NVCS-1:0]             scan_idx;
  logic [LOG_NVCS-1:0]             winner;
  logic [FLIT_WIDTH-1:0]           win_flit;
  logic [NVCS-1:0]                 cred_dec;
  logic [NVCS-1:0]                 cred_inc;

  // A VC may compete only with a head flit and at least one downstream credit
  always_comb begin
    elig = '0;
    for (int v = 0; v < NVCS; v++) begin
      elig[v] = flit_in_valid[v] && (credit_q[v] != '0);
    end
  end

  // Rotating-priority scan starting at the RR pointer
  always_comb begin
    winner   = ptr_q;
    found    = 1'b0;
    scan_idx = ptr_q;
    for (int i = 0; i < NVCS; i++) begin
      scan_idx = ptr_q + LOG_NVCS'(i);
      if (!found && elig[scan_idx]) begin
        winner = scan_idx;
        found  = 1'b1;
      end
    end
  end

  // Grant qualification; reset gating keeps dequeue low while in reset
  always_comb begin
    free  = !flit_out_valid_q || flit_out_ready;
    grant = reset && enable && free && (|elig);
  end

  // Select winner's flit slice and form the one-hot pop strobe
  always_comb begin
    win_flit = '0;
    dequeue  = '0;
    for (int v = 0; v < NVCS; v++) begin
      if (winner == LOG_NVCS'(v)) begin
        win_flit = flit_in[v*FLIT_WIDTH +: FLIT_WIDTH];
      end
    end
    if (grant) begin
      dequeue[winner] = 1'b1;
    end
  end

  // Per-VC credit consume/return events for this cycle
  always_comb begin
    cred_dec = '0;
    cred_inc = '0;
    for (int v = 0; v < NVCS; v++) begin
      cred_dec[v] = grant && (winner == LOG_NVCS'(v));
      cred_inc[v] = credit_in_valid && (credit_in_vc == LOG_NVCS'(v));
    end
  end

  // Next-state: output stage, RR pointer, credits and sticky overflow flag
  always_comb begin
    flit_out_valid_d = flit_out_valid_q;
    flit_out_d       = flit_out_q;
    flit_out_vc_d    = flit_out_vc_q;
    ptr_d            = ptr_q;
    credit_d         = credit_q;
    error_d          = error_q;

    if (grant) begin
      flit_out_valid_d = 1'b1;
      flit_out_d       = win_flit;
      flit_out_vc_d    = winner;
      ptr_d            = winner + LOG_NVCS'(1);
    end else if (enable && flit_out_valid_q && flit_out_ready) begin
      flit_out_valid_d = 1'b0;
    end

    for (int v = 0; v < NVCS; v++) begin
      if (cred_inc[v] && !cred_dec[v]) begin
        if (credit_q[v] == MAX_CNT) begin
          error_d = 1'b1;
        end else begin
          credit_d[v] = credit_q[v] + CW'(1);
        end
      end else if (cred_dec[v] && !cred_inc[v]) begin
        credit_d[v] = credit_q[v] - CW'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flit_out_valid_q <= 1'b0;
      flit_out_q       <= '0;
      flit_out_vc_q    <= '0;
      ptr_q            <= '0;
      credit_q         <= {NVCS{MAX_CNT}};
      error_q          <= 1'b0;
    end else begin
      flit_out_valid_q <= flit_out_valid_d;
      flit_out_q       <= flit_out_d;
      flit_out_vc_q    <= flit_out_vc_d;
      ptr_q            <= ptr_d;
      credit_q         <= credit_d;
      error_q          <= error_d;
    end
  end

  assign flit_out_valid = flit_out_valid_q;
  assign flit_out       = flit_out_q;
  assign flit_out_vc    = flit_out_vc_q;
  assign credit_count   = credit_q;
  assign error          = error_q;

endmodule

// File: tb/tb_flit_vc_arbiter.sv
// Testbench for flit_vc_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural credit/round-robin model.
module tb_flit_vc_arbiter;

  localparam int MAXC = 8;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [71:0] flit_in;
  logic [1:0]  flit_in_valid;
  logic [1:0]  dequeue;
  logic [35:0] flit_out;
  logic [0:0]  flit_out_vc;
  logic        flit_out_valid;
  logic        flit_out_ready;
  logic        credit_in_valid;
  logic [0:0]  credit_in_vc;
  logic [7:0]  credit_count;
  logic        error;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int          m_cred [2];
  int          m_ptr;
  bit          m_valid;
  logic [35:0] m_flit;
  int          m_vc;
  bit          m_err;
  int          m_win;

  flit_vc_arbiter #(
    .LOG_NVCS(1), .FLIT_WIDTH(36), .MAX_CREDITS(8), .CW(4)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid), .dequeue(dequeue),
    .flit_out(flit_out), .flit_out_vc(flit_out_vc), .flit_out_valid(flit_out_valid),
    .flit_out_ready(flit_out_ready), .credit_in_valid(credit_in_valid),
    .credit_in_vc(credit_in_vc), .credit_count(credit_count), .error(error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void m_reset();
    m_cred[0] = MAXC;
    m_cred[1] = MAXC;
    m_ptr     = 0;
    m_valid   = 1'b0;
    m_flit    = '0;
    m_vc      = 0;
    m_err     = 1'b0;
    m_win     = -1;
  endfunction

  // Winner: first VC from the pointer with a head flit and a credit
  function automatic void m_predict();
    int v;
    m_win = -1;
    if (enable && (!m_valid || flit_out_ready)) begin
      for (int k = 0; k < 2; k++) begin
        v = (m_ptr + k) % 2;
        if (m_win < 0 && flit_in_valid[v] && m_cred[v] > 0) m_win = v;
      end
    end
  endfunction

  function automatic void m_commit();
    int n;
    for (int v = 0; v < 2; v++) begin
      n = m_cred[v] + ((credit_in_valid && int'(credit_in_vc) == v) ? 1 : 0)
                    - ((m_win == v) ? 1 : 0);
      if (n > MAXC) begin
        n = MAXC;
        m_err = 1'b1;
      end
      m_cred[v] = n;
    end
    if (m_win >= 0) begin
      m_flit  = flit_in[m_win*36 +: 36];
      m_vc    = m_win;
      m_valid = 1'b1;
      m_ptr   = (m_win + 1) % 2;
    end else if (enable && m_valid && flit_out_ready) begin
      m_valid = 1'b0;
    end
  endfunction

  function automatic logic [1:0] exp_deq();
    if (m_win < 0) return 2'b00;
    return 2'(1 << m_win);
  endfunction

  function automatic logic [7:0] exp_cc();
    return {4'(m_cred[1]), 4'(m_cred[0])};
  endfunction

  function automatic logic [35:0] rflit();
    return 36'({$urandom(), $urandom()});
  endfunction

  task automatic drive(input logic en, input logic [1:0] vin, input logic [35:0] f0,
                       input logic [35:0] f1, input logic rdy, input logic cv, input logic cvc);
    enable          = en;
    flit_in_valid   = vin;
    flit_in         = {f1, f0};
    flit_out_ready  = rdy;
    credit_in_valid = cv;
    credit_in_vc    = cvc;
  endtask

  task automatic settle();
    #1;
    m_predict();
  endtask

  task automatic tick();
    m_commit();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(posedge clock);
    #1;
    m_reset();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 2'b01, 36'hA5, '0, 1'b1, 1'b0, 1'b0);
    #1 reset = 1'b0;
    #2;
    m_reset();
    checks++; if (flit_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", flit_out_valid); end
    checks++; if (flit_out !== 36'h0) begin errors++; $display("FAIL reset_flit got %h exp 0", flit_out); end
    checks++; if (flit_out_vc !== 1'b0) begin errors++; $display("FAIL reset_vc got %b exp 0", flit_out_vc); end
    checks++; if (credit_count !== 8'h88) begin errors++; $display("FAIL reset_credits got %h exp 88", credit_count); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", error); end
    checks++; if (dequeue !== 2'b00) begin errors++; $display("FAIL reset_dequeue got %b exp 00", dequeue); end
    @(posedge clock);
    #1;
    checks++; if (dequeue !== 2'b00) begin errors++; $display("FAIL reset_dequeue_edge got %b exp 00", dequeue); end
    reset = 1'b1;
  endtask

  task automatic test_single();
    drive(1'b1, 2'b01, 36'hA5, '0, 1'b1, 1'b0, 1'b0);
    settle();
    checks++; if (dequeue !== 2'b01) begin errors++; $display("FAIL single_dequeue got %b exp 01", dequeue); end
    tick();
    drive(1'b1, 2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
    checks++; if (flit_out !== 36'hA5) begin errors++; $display("FAIL single_flit got %h exp a5", flit_out); end
    checks++; if (flit_out_vc !== 1'b0) begin errors++; $display("FAIL single_vc got %b exp 0", flit_out_vc); end
    checks++; if (flit_out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", flit_out_valid); end
    checks++; if (credit_count[3:0] !== 4'd7) begin errors++; $display("FAIL single_credit0 got %0d exp 7", credit_count[3:0]); end
  endtask

  task automatic test_alternate();
    logic [35:0] f0, f1;
    for (int i = 0; i < 8; i++) begin
      f0 = rflit();
      f1 = rflit();
      drive(1'b1, 2'b11, f0, f1, 1'b1, 1'b0, 1'b0);
      settle();
      checks++;
      if (dequeue !== 2'(1 << ((i + 1) % 2))) begin
        errors++; $display("FAIL alt_dequeue[%0d] got %b exp %b", i, dequeue, 2'(1 << ((i + 1) % 2)));
      end
      tick();
      checks++;
      if (flit_out !== (((i + 1) % 2 == 1) ? f1 : f0) || flit_out_valid !== 1'b1) begin
        errors++; $display("FAIL alt_flit[%0d] got %h/%b exp %h/1", i, flit_out, flit_out_valid,
                           (((i + 1) % 2 == 1) ? f1 : f0));
      end
    end
    checks++; if (credit_count !== exp_cc()) begin errors++; $display("FAIL alt_credits got %h exp %h", credit_count, exp_cc()); end
  endtask

  task automatic test_exhaust();
    int grants;
    logic [35:0] f;
    do_reset();
    grants = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 2'b01, rflit(), '0, 1'b1, 1'b0, 1'b0);
      settle();
      if (dequeue === 2'b01) grants++;
      checks++; if (dequeue !== exp_deq()) begin errors++; $display("FAIL exh_dequeue[%0d] got %b exp %b", i, dequeue, exp_deq()); end
      tick();
    end
    checks++; if (grants !== 8) begin errors++; $display("FAIL exh_grants got %0d exp 8", grants); end
    checks++; if (credit_count[3:0] !== 4'd0) begin errors++; $display("FAIL exh_credit0 got %0d exp 0", credit_count[3:0]); end
    f = rflit();
    drive(1'b1, 2'b01, f, '0, 1'b1, 1'b1, 1'b0);
    settle();
    checks++; if (dequeue !== 2'b00) begin errors++; $display("FAIL exh_return_cycle got %b exp 00", dequeue); end
    tick();
    checks++; if (credit_count[3:0] !== 4'd1) begin errors++; $display("FAIL exh_credit_ret got %0d exp 1", credit_count[3:0]); end
    drive(1'b1, 2'b01, f, '0, 1'b1, 1'b0, 1'b0);
    settle();
    checks++; if (dequeue !== 2'b01) begin errors++; $display("FAIL exh_regrant got %b exp 01", dequeue); end
    tick();
    checks++; if (flit_out !== f || credit_count[3:0] !== 4'd0) begin
      errors++; $display("FAIL exh_after got %h/%0d exp %h/0", flit_out, credit_count[3:0], f);
    end
    drive(1'b1, 2'b01, rflit(), '0, 1'b1, 1'b0, 1'b0);
    settle();
    checks++; if (dequeue !== 2'b00) begin errors++; $display("FAIL exh_final got %b exp 00", dequeue); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [35:0] held, fn;
    do_reset();
    held = rflit();
    drive(1'b1, 2'b10, '0, held, 1'b1, 1'b0, 1'b0);
    settle();
    checks++; if (dequeue !== 2'b10) begin errors++; $display("FAIL bp_first got %b exp 10", dequeue); end
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b10, '0, rflit(), 1'b0, 1'b0, 1'b0);
      settle();
      checks++; if (dequeue !== 2'b00) begin errors++; $display("FAIL bp_dequeue[%0d] got %b exp 00", i, dequeue); end
      tick();
      checks++;
      if (flit_out !== held || flit_out_vc !== 1'b1 || flit_out_valid !== 1'b1 || credit_count[7:4] !== 4'd7) begin
        errors++; $display("FAIL bp_hold[%0d] got %h/%b/%b/%0d exp %h/1/1/7", i, flit_out, flit_out_vc,
                           flit_out_valid, credit_count[7:4], held);
      end
    end
    fn = rflit();
    drive(1'b1, 2'b10, '0, fn, 1'b1, 1'b0, 1'b0);
    settle();
    checks++; if (dequeue !== 2'b10) begin errors++; $display("FAIL bp_release got %b exp 10", dequeue); end
    tick();
    checks++; if (flit_out !== fn || flit_out_valid !== 1'b1 || credit_count[7:4] !== 4'd6) begin
      errors++; $display("FAIL bp_new got %h/%b/%0d exp %h/1/6", flit_out, flit_out_valid, credit_count[7:4], fn);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    drive(1'b1, 2'b01, rflit(), '0, 1'b1, 1'b1, 1'b0);
    settle();
    checks++; if (dequeue !== 2'b01) begin errors++; $display("FAIL ovf_grant got %b exp 01", dequeue); end
    tick();
    checks++; if (credit_count !== 8'h88 || error !== 1'b0) begin
      errors++; $display("FAIL ovf_net_zero got %h/%b exp 88/0", credit_count, error);
    end
    drive(1'b1, 2'b00, '0, '0, 1'b1, 1'b1, 1'b1);
    settle();
    tick();
    checks++; if (credit_count !== 8'h88 || error !== 1'b1) begin
      errors++; $display("FAIL ovf_set got %h/%b exp 88/1", credit_count, error);
    end
    drive(1'b1, 2'b00, '0, '0, 1'b1, 1'b0, 1'b0);
    settle();
    tick();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", error); end
  endtask

  task automatic test_enable();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 2'b11, rflit(), rflit(), 1'b1, 1'b0, 1'b0);
      settle();
      checks++; if (dequeue !== 2'b00) begin errors++; $display("FAIL en_dequeue[%0d] got %b exp 00", i, dequeue); end
      tick();
      checks++; if (flit_out_valid !== 1'b0 || credit_count !== 8'h88) begin
        errors++; $display("FAIL en_hold[%0d] got %b/%h exp 0/88", i, flit_out_valid, credit_count);
      end
    end
    drive(1'b1, 2'b11, rflit(), rflit(), 1'b1, 1'b0, 1'b0);
    settle();
    checks++; if (dequeue !== 2'b01) begin errors++; $display("FAIL en_resume got %b exp 01", dequeue); end
    tick();
  endtask

  task automatic test_random();
    logic cv;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cv = ($urandom_range(0, 7) < ((i < 200) ? 1 : 3));
      drive(1'b1, 2'($urandom_range(0, 3)), rflit(), rflit(), ($urandom_range(0, 3) != 0),
            cv, 1'($urandom_range(0, 1)));
      settle();
      checks++; if (dequeue !== exp_deq()) begin errors++; $display("FAIL rnd_dequeue[%0d] got %b exp %b", i, dequeue, exp_deq()); end
      tick();
      checks++;
      if (flit_out_valid !== m_valid || flit_out !== m_flit || flit_out_vc !== 1'(m_vc) ||
          credit_count !== exp_cc() || error !== m_err) begin
        errors++; $display("FAIL rnd_state[%0d] got v%b f%h c%b cc%h e%b exp v%b f%h c%0d cc%h e%b", i,
                           flit_out_valid, flit_out, flit_out_vc, credit_count, error,
                           m_valid, m_flit, m_vc, exp_cc(), m_err);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, 2'b01, rflit(), '0, 1'b1, 1'b1, 1'b1);
    settle();
    tick();
    drive(1'b1, 2'b11, rflit(), rflit(), 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (flit_out_valid !== 1'b1 || error !== 1'b1) begin
      errors++; $display("FAIL mid_pre got %b/%b exp 1/1", flit_out_valid, error);
    end
    reset = 1'b0;
    #1;
    m_reset();
    checks++;
    if (flit_out_valid !== 1'b0 || flit_out !== 36'h0 || flit_out_vc !== 1'b0 ||
        credit_count !== 8'h88 || error !== 1'b0 || dequeue !== 2'b00) begin
      errors++; $display("FAIL mid_reset got v%b f%h c%b cc%h e%b d%b exp v0 f0 c0 cc88 e0 d00",
                         flit_out_valid, flit_out, flit_out_vc, credit_count, error, dequeue);
    end
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(1'b1, 2'b11, rflit(), rflit(), 1'b1, 1'b0, 1'b0);
    settle();
    checks++; if (dequeue !== 2'b01) begin errors++; $display("FAIL mid_first got %b exp 01", dequeue); end
    tick();
    checks++; if (flit_out_vc !== 1'b0 || flit_out_valid !== 1'b1) begin
      errors++; $display("FAIL mid_first_out got %b/%b exp 0/1", flit_out_vc, flit_out_valid);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single();
    test_alternate();
    test_exhaust();
    test_backpressure();
    test_overflow();
    test_enable();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
